mem_stage_access_ctrl: RTL and testbench
========================================

Name: mem_stage_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage.
- Consumes the control, address and store-data fields held in the EX/MEM pipeline register.
- Runs a request/acknowledge handshake with a variable-latency data memory.
- Drives the pipeline-wide stall that freezes the EX/MEM enable (and upstream enables) until the access completes. Also owns halt detection at MEM.

Parameters:
- ADDR_W, 16, data-memory address width
- DATA_W, 16, data width
- TIMEOUT_CYCLES, 255, WAIT-state cycle limit; used only with MEM_TIMEOUT_EN

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- MEM_DMEM_en  input  1  data-memory enable from EX/MEM
- MEM_MemRead  input  1  load instruction in MEM
- MEM_MemWrite  input  1  store instruction in MEM
- MEM_Hlt  input  1  halt instruction in MEM
- MEM_Fresult  input  ADDR_W  access address
- MEM_rt_reg_data  input  DATA_W  store data
- pipe_adv  input  1  EX/MEM register loads this cycle (its enable after all stall sources are combined)
- dmem_ack  input  1  memory completion strobe, one cycle
- dmem_rdata  input  DATA_W  read data, valid with dmem_ack
- dmem_req  output  1  request, held high until ack
- dmem_we  output  1  1 = write, 0 = read
- dmem_addr  output  ADDR_W  registered address
- dmem_wdata  output  DATA_W  registered write data
- mem_stall  output  1  combinational; hold IF/ID, ID/EX, EX/MEM
- mem_rdata  output  DATA_W  captured load data to MEM/WB
- mem_rdata_vld  output  1  mem_rdata valid for current instruction
- mem_halted  output  1  sticky halt indication
- mem_err  output  1  sticky timeout error

Behaviour:
- Access condition: acc = MEM_DMEM_en & (MEM_MemRead | MEM_MemWrite). If both MemRead and MemWrite are set, the access is a write.
- Reset: state=IDLE. dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_rdata, mem_rdata_vld, mem_halted and mem_err are all 0. rst takes priority over every other input.
- State IDLE:
  - mem_stall = acc.
  - If acc: latch addr, wdata and we=MemWrite; set dmem_req=1; go to WAIT.
  - Else if MEM_Hlt: go to HALT.
  - Else: stay in IDLE.
- State WAIT:
  - dmem_req=1, mem_stall=1.
  - On dmem_ack: capture dmem_rdata into mem_rdata (reads only; writes leave it unchanged), clear dmem_req, go to DONE.
  - An ack arriving in the same cycle that req first appears is legal.
- State DONE:
  - mem_stall=0; mem_rdata_vld=1 for reads.
  - If pipe_adv: clear mem_rdata_vld, go to IDLE.
  - Else stay in DONE, so an external stall cannot cause a re-issue.
- State HALT:
  - mem_halted=1, mem_stall=1, no requests.
  - Exits only on rst.
- Latency: minimum 2 stall cycles per access (IDLE detect, WAIT with same-cycle ack). Each extra cycle of memory latency adds exactly one stall cycle.
- dmem_addr and dmem_wdata remain stable for the whole request.
- dmem_ack seen in IDLE, DONE or HALT: ignored.
- Reset during WAIT: request dropped the next cycle; a late ack is ignored.
- Halt with a simultaneous access: the access completes first; halt is re-evaluated in IDLE after the pipeline advances.
- No combinational path from dmem_ack to dmem_req.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop dmem_req, set mem_err=1 (sticky until rst), force mem_rdata to all ones, go to DONE.
- When undefined: WAIT persists indefinitely; mem_err is tied to 0; no counter logic.

Test Plan:
- Load, ack in the same cycle as req, addr 16'h0040, rdata 16'hBEEF -> mem_stall high exactly 2 cycles, dmem_we=0, mem_rdata=16'hBEEF with vld in DONE.
- Store to 16'h0010 with data 16'h1234, ack after 3 cycles -> dmem_we=1, addr/wdata stable throughout req, stall for 5 cycles, mem_rdata unchanged.
- Load completes while pipe_adv=0 for 2 cycles -> stays in DONE, no second dmem_req, vld held until pipe_adv=1.
- Back-to-back loads at 16'h0002 then 16'h0004 -> exactly two requests, each with the correct address.
- MEM_Hlt with acc=0 -> mem_halted=1 and mem_stall=1 next cycle; ack and new acc ignored until rst. rst asserted mid-WAIT -> all outputs 0 next cycle.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> req drops after 4 WAIT cycles, mem_err=1, mem_rdata=16'hFFFF.

Source files
------------

// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage data-memory access sequencer: req/ack handshake, pipeline stall and halt detection.
// Optional WAIT-state timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_access_ctrl #(
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_DMEM_en,
   input  logic              MEM_MemRead,
   input  logic              MEM_MemWrite,
   input  logic              MEM_Hlt,
   input  logic [ADDR_W-1:0] MEM_Fresult,
   input  logic [DATA_W-1:0] MEM_rt_reg_data,
   input  logic              pipe_adv,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic              mem_stall,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_rdata_vld,
   output logic              mem_halted,
   output logic              mem_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2,
      S_HALT = 2'd3
   } state_t;

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be non-zero");
   end

   state_t              r_state, w_state_nxt;
   logic                w_acc;
   logic                w_stall;
   logic                r_req, w_req_nxt;
   logic                r_we, w_we_nxt;
   logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
   logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
   logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
   logic                r_vld, w_vld_nxt;
   logic                r_halted, w_halted_nxt;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic                r_err, w_err_nxt;
`endif

   assign w_acc = MEM_DMEM_en & (MEM_MemRead | MEM_MemWrite);

   // Next-state and next-register values; the stall is the only combinational output
   always_comb begin
      w_state_nxt  = r_state;
      w_stall      = 1'b0;
      w_req_nxt    = r_req;
      w_we_nxt     = r_we;
      w_addr_nxt   = r_addr;
      w_wdata_nxt  = r_wdata;
      w_rdata_nxt  = r_rdata;
      w_vld_nxt    = r_vld;
      w_halted_nxt = r_halted;
`ifdef MEM_TIMEOUT_EN
      w_cnt_nxt    = r_cnt;
      w_err_nxt    = r_err;
`endif
      case (r_state)
         S_IDLE: begin
            w_stall = w_acc;
            if (w_acc) begin
               w_addr_nxt  = MEM_Fresult;
               w_wdata_nxt = MEM_rt_reg_data;
               w_we_nxt    = MEM_MemWrite;
               w_req_nxt   = 1'b1;
               w_state_nxt = S_WAIT;
`ifdef MEM_TIMEOUT_EN
               w_cnt_nxt   = '0;
`endif
            end else if (MEM_Hlt) begin
               w_halted_nxt = 1'b1;
               w_state_nxt  = S_HALT;
            end
         end
         S_WAIT: begin
            w_stall = 1'b1;
            if (dmem_ack) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = S_DONE;
               if (!r_we) begin
                  w_rdata_nxt = dmem_rdata;
                  w_vld_nxt   = 1'b1;
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (r_cnt == CNT_LAST) begin
               w_req_nxt   = 1'b0;
               w_err_nxt   = 1'b1;
               w_rdata_nxt = '1;
               w_vld_nxt   = ~r_we;
               w_state_nxt = S_DONE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
`endif
         end
         S_DONE: begin
            // Parked here until the pipeline advances so a held instruction is not re-issued
            if (pipe_adv) begin
               w_vld_nxt   = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         S_HALT: begin
            w_stall = 1'b1;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_req    <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_vld    <= 1'b0;
         r_halted <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         r_cnt    <= '0;
         r_err    <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_req    <= w_req_nxt;
         r_we     <= w_we_nxt;
         r_addr   <= w_addr_nxt;
         r_wdata  <= w_wdata_nxt;
         r_rdata  <= w_rdata_nxt;
         r_vld    <= w_vld_nxt;
         r_halted <= w_halted_nxt;
`ifdef MEM_TIMEOUT_EN
         r_cnt    <= w_cnt_nxt;
         r_err    <= w_err_nxt;
`endif
      end
   end

   assign dmem_req      = r_req;
   assign dmem_we       = r_we;
   assign dmem_addr     = r_addr;
   assign dmem_wdata    = r_wdata;
   assign mem_stall     = w_stall;
   assign mem_rdata     = r_rdata;
   assign mem_rdata_vld = r_vld;
   assign mem_halted    = r_halted;
`ifdef MEM_TIMEOUT_EN
   assign mem_err       = r_err;
`else
   assign mem_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Randomized bench for mem_stage_access_ctrl against an instruction-level model of the MEM stage.
// Adds a timeout scenario when MEM_TIMEOUT_EN is defined.
module tb_mem_stage_access_ctrl;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
`ifdef MEM_TIMEOUT_EN
   localparam int unsigned TO      = 4;
   localparam int unsigned MAX_LAT = 3;
`else
   localparam int unsigned TO      = 255;
   localparam int unsigned MAX_LAT = 6;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          MEM_DMEM_en;
   logic          MEM_MemRead;
   logic          MEM_MemWrite;
   logic          MEM_Hlt;
   logic [AW-1:0] MEM_Fresult;
   logic [DW-1:0] MEM_rt_reg_data;
   logic          pipe_adv;
   logic          dmem_ack;
   logic [DW-1:0] dmem_rdata;
   logic          dmem_req;
   logic          dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic          mem_stall;
   logic [DW-1:0] mem_rdata;
   logic          mem_rdata_vld;
   logic          mem_halted;
   logic          mem_err;

   mem_stage_access_ctrl #(
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (TO)
   ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .MEM_DMEM_en     (MEM_DMEM_en),
      .MEM_MemRead     (MEM_MemRead),
      .MEM_MemWrite    (MEM_MemWrite),
      .MEM_Hlt         (MEM_Hlt),
      .MEM_Fresult     (MEM_Fresult),
      .MEM_rt_reg_data (MEM_rt_reg_data),
      .pipe_adv        (pipe_adv),
      .dmem_ack        (dmem_ack),
      .dmem_rdata      (dmem_rdata),
      .dmem_req        (dmem_req),
      .dmem_we         (dmem_we),
      .dmem_addr       (dmem_addr),
      .dmem_wdata      (dmem_wdata),
      .mem_stall       (mem_stall),
      .mem_rdata       (mem_rdata),
      .mem_rdata_vld   (mem_rdata_vld),
      .mem_halted      (mem_halted),
      .mem_err         (mem_err)
   );

   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] mem_model [logic [AW-1:0]];
   logic [DW-1:0] model_rdata;
   logic          model_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      MEM_DMEM_en     = 1'b0;
      MEM_MemRead     = 1'b0;
      MEM_MemWrite    = 1'b0;
      MEM_Hlt         = 1'b0;
      MEM_Fresult     = 16'($urandom);
      MEM_rt_reg_data = 16'($urandom);
      pipe_adv        = 1'b1;
      dmem_ack        = 1'b0;
      dmem_rdata      = 16'($urandom);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_idle();
      next_cycle();
      next_cycle();
      rst         = 1'b0;
      model_rdata = '0;
      model_err   = 1'b0;
   endtask

   task automatic check_cleared(input string pfx);
      check_eq({pfx, "_req"},    32'(dmem_req),      32'd0);
      check_eq({pfx, "_we"},     32'(dmem_we),       32'd0);
      check_eq({pfx, "_addr"},   32'(dmem_addr),     32'd0);
      check_eq({pfx, "_wdata"},  32'(dmem_wdata),    32'd0);
      check_eq({pfx, "_rdata"},  32'(mem_rdata),     32'd0);
      check_eq({pfx, "_vld"},    32'(mem_rdata_vld), 32'd0);
      check_eq({pfx, "_halted"}, 32'(mem_halted),    32'd0);
      check_eq({pfx, "_err"},    32'(mem_err),       32'd0);
      check_eq({pfx, "_stall"},  32'(mem_stall),     32'd0);
   endtask

   // One instruction with a memory access; memory acks after 'lat' request cycles,
   // then the pipeline is held for 'hold' cycles before it advances.
   task automatic run_access(input bit rd, input bit wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input int lat, input int hold,
                             input bit hlt);
      int   stall_n = 0;
      int   rises   = 0;
      int   req_n   = 0;
      bit   is_wr   = wr;
      logic prev_req = 1'b0;
      MEM_DMEM_en     = 1'b1;
      MEM_MemRead     = rd;
      MEM_MemWrite    = wr;
      MEM_Hlt         = hlt;
      MEM_Fresult     = addr;
      MEM_rt_reg_data = wdata;
      pipe_adv        = 1'b0;
      dmem_ack        = 1'b0;
      for (int cyc = 0; cyc < 64; cyc++) begin
         @(negedge clk);
         if (cyc == 0) check_eq("idle_vld", 32'(mem_rdata_vld), 32'd0);
         if (!mem_stall) break;
         stall_n++;
         if (dmem_req) begin
            if (!prev_req) rises++;
            check_eq("req_addr", 32'(dmem_addr), 32'(addr));
            check_eq("req_we", 32'(dmem_we), 32'(is_wr));
            if (is_wr) check_eq("req_wdata", 32'(dmem_wdata), 32'(wdata));
            if (req_n == lat) begin
               dmem_ack = 1'b1;
               if (is_wr) begin
                  mem_model[addr] = wdata;
               end else begin
                  if (!mem_model.exists(addr)) mem_model[addr] = 16'($urandom);
                  dmem_rdata  = mem_model[addr];
                  model_rdata = mem_model[addr];
               end
            end
            req_n++;
         end
         prev_req = dmem_req;
         @(posedge clk);
         #1;
         dmem_ack   = 1'b0;
         dmem_rdata = 16'($urandom);
      end
      check_eq("stall_cycles", 32'(stall_n), 32'(2 + lat));
      check_eq("req_count", 32'(rises), 32'd1);
      check_eq("done_req", 32'(dmem_req), 32'd0);
      check_eq("done_rdata", 32'(mem_rdata), 32'(model_rdata));
      check_eq("done_vld", 32'(mem_rdata_vld), 32'(!is_wr));
      check_eq("done_halted", 32'(mem_halted), 32'd0);
      check_eq("done_err", 32'(mem_err), 32'(model_err));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         dmem_ack   = 1'($urandom_range(0, 1));
         dmem_rdata = 16'($urandom);
         @(negedge clk);
         check_eq("hold_stall", 32'(mem_stall), 32'd0);
         check_eq("hold_req", 32'(dmem_req), 32'd0);
         check_eq("hold_vld", 32'(mem_rdata_vld), 32'(!is_wr));
         check_eq("hold_rdata", 32'(mem_rdata), 32'(model_rdata));
      end
      pipe_adv = 1'b1;
      next_cycle();
      dmem_ack = 1'b0;
   endtask

   // One instruction without a data access; spurious acks must be ignored
   task automatic run_nop();
      drive_idle();
      if ($urandom_range(0, 1) == 1) begin
         MEM_MemRead  = 1'($urandom_range(0, 1));
         MEM_MemWrite = 1'($urandom_range(0, 1));
      end else begin
         MEM_DMEM_en = 1'b1;
      end
      dmem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("nop_stall", 32'(mem_stall), 32'd0);
      check_eq("nop_req", 32'(dmem_req), 32'd0);
      check_eq("nop_vld", 32'(mem_rdata_vld), 32'd0);
      check_eq("nop_halted", 32'(mem_halted), 32'd0);
      next_cycle();
      dmem_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      do_reset();
      @(negedge clk);
      check_cleared("reset");
      next_cycle();

      // Directed scenarios
      mem_model[16'h0040] = 16'hBEEF;
      run_access(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 0, 1'b0);
      check_eq("tp_load_beef", 32'(mem_rdata), 32'h0000BEEF);
      run_access(1'b0, 1'b1, 16'h0010, 16'h1234, 3, 0, 1'b0);
      check_eq("tp_store_keep", 32'(mem_rdata), 32'h0000BEEF);
      run_access(1'b1, 1'b0, 16'h0010, 16'h0000, 1, 2, 1'b0);
      check_eq("tp_load_back", 32'(mem_rdata), 32'h00001234);
      run_access(1'b1, 1'b0, 16'h0002, 16'h0000, 0, 0, 1'b0);
      run_access(1'b1, 1'b0, 16'h0004, 16'h0000, 2, 0, 1'b0);
      run_access(1'b1, 1'b1, 16'h0006, 16'h7777, 0, 1, 1'b1);
      run_nop();

      // Randomized instruction stream
      for (int i = 0; i < 150; i++) begin
         int kind;
         kind = int'($urandom_range(0, 4));
         if (kind == 0) begin
            run_nop();
         end else begin
            run_access((kind != 2), (kind == 2 || kind == 3),
                       16'($urandom_range(0, 15) << 1), 16'($urandom),
                       int'($urandom_range(0, MAX_LAT)), int'($urandom_range(0, 3)),
                       ($urandom_range(0, 3) == 0));
         end
      end

`ifdef MEM_TIMEOUT_EN
      begin : timeout_test
         int st;
         int req_cyc;
         st      = 0;
         req_cyc = 0;
         MEM_DMEM_en  = 1'b1;
         MEM_MemRead  = 1'b1;
         MEM_MemWrite = 1'b0;
         MEM_Hlt      = 1'b0;
         MEM_Fresult  = 16'h0030;
         pipe_adv     = 1'b0;
         dmem_ack     = 1'b0;
         for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (!mem_stall) break;
            st++;
            if (dmem_req) req_cyc++;
            next_cycle();
         end
         model_rdata = '1;
         model_err   = 1'b1;
         check_eq("to_stall", 32'(st), 32'(1 + TO));
         check_eq("to_req_cycles", 32'(req_cyc), 32'(TO));
         check_eq("to_req", 32'(dmem_req), 32'd0);
         check_eq("to_err", 32'(mem_err), 32'd1);
         check_eq("to_rdata", 32'(mem_rdata), 32'h0000FFFF);
         check_eq("to_vld", 32'(mem_rdata_vld), 32'd1);
         pipe_adv = 1'b1;
         next_cycle();
         run_nop();
         check_eq("to_err_sticky", 32'(mem_err), 32'd1);
         run_access(1'b0, 1'b1, 16'h0008, 16'h4321, 1, 0, 1'b0);
      end
`endif

      // Reset during WAIT: request dropped, late ack ignored
      run_access(1'b1, 1'b0, 16'h0050, 16'h0000, 0, 0, 1'b0);
      MEM_DMEM_en     = 1'b1;
      MEM_MemRead     = 1'b0;
      MEM_MemWrite    = 1'b1;
      MEM_Fresult     = 16'h0ABC;
      MEM_rt_reg_data = 16'h5A5A;
      pipe_adv        = 1'b0;
      next_cycle();
      @(negedge clk);
      check_eq("midwait_req", 32'(dmem_req), 32'd1);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      drive_idle();
      dmem_ack    = 1'b1;
      model_rdata = '0;
      model_err   = 1'b0;
      @(negedge clk);
      check_cleared("midwait_rst");
      next_cycle();
      dmem_ack = 1'b0;
      @(negedge clk);
      check_eq("late_ack_req", 32'(dmem_req), 32'd0);
      check_eq("late_ack_vld", 32'(mem_rdata_vld), 32'd0);
      next_cycle();

      // Halt: entered from IDLE, ignores acks and accesses until reset
      drive_idle();
      MEM_Hlt = 1'b1;
      @(negedge clk);
      check_eq("hlt_detect_stall", 32'(mem_stall), 32'd0);
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         MEM_Hlt      = 1'b0;
         MEM_DMEM_en  = 1'b1;
         MEM_MemRead  = 1'b1;
         pipe_adv     = 1'b0;
         dmem_ack     = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_eq("halt_halted", 32'(mem_halted), 32'd1);
         check_eq("halt_stall", 32'(mem_stall), 32'd1);
         check_eq("halt_req", 32'(dmem_req), 32'd0);
         next_cycle();
      end
      rst = 1'b1;
      drive_idle();
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check_cleared("halt_rst");
      next_cycle();
      run_access(1'b1, 1'b0, 16'h0040, 16'h0000, 1, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
